pc_fetch_ctrl: RTL and testbench
================================

# pc_fetch_ctrl

Program-counter owner at the fetch end of the branch-resolution path: consumes the branch unit's `PcSel`/`BrPC` redirect request and `Halt`, holds the architectural fetch PC, and sequences pipeline flush, stall hold and halt. It sits between the EX-stage branch logic and instruction memory. It replaces the bare PC flop and next-PC mux with a small controller that has defined priority, flush timing, a misaligned-target trap and a redirect statistic.

## Interface
Parameters:
- `PC_W`, 9, fetch PC width; `BrPC` is truncated to this width.
- `FLUSH_CYC`, 2, number of cycles `Flush` stays high after an accepted redirect (range 1-7).
- `CNT_W`, 16, width of the saturating redirect counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset; `reset`=0 at a rising edge resets the block.
- `Stall`  in  1  hazard-unit hold request; hold the PC this cycle.
- `PcSel`  in  1  redirect request from branch resolution; 1 means taken.
- `BrPC`  in  32  redirect target; valid when `PcSel`=1.
- `Halt`  in  1  halt request from the decoded halt instruction.
- `PC`  out  PC_W  current fetch address (registered).
- `Flush`  out  1  registered flush of the IF/ID and ID/EX registers.
- `Halted`  out  1  block is in HALT (registered).
- `Trap`  out  1  sticky misaligned-target flag (registered).
- `RedirectCnt`  out  CNT_W  saturating count of accepted redirects.

## Operation
- States: RUN, FLUSH, HALT.
- Priority each cycle: reset > Halt > misaligned redirect > redirect > Stall > sequential.
- Halt=1 in RUN/FLUSH: next state HALT. PC frozen. `Flush` set to 1 for one cycle, then 0. `Halted`=1 from the next cycle.
- Misaligned redirect: PcSel=1 with BrPC[1:0]≠0 and Halt=0. Same as Halt, and `Trap`<=1. PC is not loaded and the counter does not count.
- Aligned redirect (PcSel=1, BrPC[1:0]=0, Halt=0) in RUN or FLUSH:
  - PC <= BrPC[PC_W-1:0]; upper bits ignored.
  - Next state FLUSH. Flush counter loads FLUSH_CYC.
  - RedirectCnt increments and saturates at all-ones.
  - The redirect wins over Stall.
  - A redirect during FLUSH restarts the counter at FLUSH_CYC.
- Stall=1 with no redirect/halt: PC holds. The flush countdown still decrements.
- Otherwise: PC <= PC + 4, modulo 2^PC_W (wraps to 0).
- FLUSH: `Flush`=1 while the counter is non-zero. The counter decrements each cycle. When it reaches 0, the next state is RUN and `Flush`=0.
- HALT: absorbing. All inputs are ignored and all outputs are frozen, except `Flush`=0. Exit only via reset.

## Timing
- Reset values: PC=0, state RUN, Flush=0, Halted=0, Trap=0, RedirectCnt=0, flush counter=0.
- Reset asserted mid-FLUSH or in HALT takes effect at that edge with the values above.
- Redirect latency:
  - PcSel sampled at edge N.
  - PC=BrPC visible after edge N.
  - Flush=1 after edges N through N+FLUSH_CYC-1, and 0 after edge N+FLUSH_CYC, if no further redirect.
- Halt latency: Halted=1 after the edge that sampled Halt=1.
- All outputs are registered. There is no combinational input-to-output path.

## Structure
- Package `pc_ctrl_pkg`:
  - `typedef enum logic [1:0] {RUN, FLUSH, HALT} pc_state_t`.
  - `localparam PC_STEP = 4`.
  - Default FLUSH_CYC and CNT_W constants.
- Sub-module `sat_counter #(W)` (enable, synchronous active-low reset, saturating increment) implements `RedirectCnt`.
- The flush countdown and next-PC mux stay inline in `pc_fetch_ctrl`.

## Test plan
- Reset then 5 idle cycles: PC goes 0, 4, 8, 12, 16, 20; Flush=0; Halted=0.
- At PC=8, PcSel=1 and BrPC=0x40 for one cycle:
  - Next PC=0x40, then 0x44, 0x48.
  - Flush=1 for exactly 2 cycles.
  - RedirectCnt=1.
- PcSel=1, BrPC=0x100 together with Stall=1: redirect taken, PC=0x100 (PC_W=9 keeps bit 8). A second redirect to 0x20 one cycle later restarts the countdown, so Flush stays high for 3 consecutive cycles in total.
- Stall=1 for 3 cycles at PC=0x10: PC stays 0x10 for those cycles, then 0x14.
- PcSel=1 with BrPC=0x42:
  - Trap=1 and Halted=1 on the next cycle.
  - PC unchanged; RedirectCnt unchanged.
  - Further PcSel pulses are ignored until reset=0 for one edge, which restores PC=0 and Trap=0.
- Wrap: starting at PC=0x1FC with no events, the next PC is 0x000. With CNT_W=2, 5 redirects leave RedirectCnt=3.

Source files
------------

// File: rtl/pc_ctrl_pkg.sv
// rtl/pc_ctrl_pkg.sv - shared state type and constants for the fetch PC controller
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } pc_state_t;

    localparam int PC_STEP       = 4;
    localparam int FLUSH_CYC_DEF = 2;
    localparam int CNT_W_DEF     = 16;
    localparam int FCNT_W        = 3;

endpackage

// File: rtl/pc_fetch_ctrl_sat_counter.sv
// rtl/pc_fetch_ctrl_sat_counter.sv - saturating up-counter with enable
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         i_en,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - fetch PC owner: redirect, flush countdown, stall hold, halt and trap
module pc_fetch_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int PC_W      = 9,
    parameter int FLUSH_CYC = FLUSH_CYC_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Stall,
    input  logic             PcSel,
    input  logic [31:0]      BrPC,
    input  logic             Halt,
    output logic [PC_W-1:0]  PC,
    output logic             Flush,
    output logic             Halted,
    output logic             Trap,
    output logic [CNT_W-1:0] RedirectCnt
);

    pc_state_t         r_state;
    pc_state_t         w_state_nxt;
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   w_pc_nxt;
    logic [FCNT_W-1:0] r_fcnt;
    logic [FCNT_W-1:0] w_fcnt_nxt;
    logic [FCNT_W-1:0] w_fcnt_dec;
    logic              r_flush;
    logic              w_flush_nxt;
    logic              r_halted;
    logic              r_trap;
    logic              w_trap_nxt;
    logic              w_redir;
    logic              w_misal;
    logic              w_unused;

    // Target bits above the fetch window are architecturally ignored.
    assign w_unused   = ^BrPC[31:PC_W];
    assign w_misal    = PcSel && (BrPC[1:0] != 2'b00);
    assign w_fcnt_dec = (r_fcnt != '0) ? (r_fcnt - FCNT_W'(1)) : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_fcnt_nxt  = r_fcnt;
        w_flush_nxt = 1'b0;
        w_trap_nxt  = r_trap;
        w_redir     = 1'b0;
        case (r_state)
            HALT: begin
                // Absorbing: only reset leaves; Flush drops after the entry cycle.
            end
            default: begin
                if (Halt || w_misal) begin
                    w_state_nxt = HALT;
                    w_flush_nxt = 1'b1;
                    w_fcnt_nxt  = '0;
                    w_trap_nxt  = r_trap | (w_misal & ~Halt);
                end else if (PcSel) begin
                    w_pc_nxt    = BrPC[PC_W-1:0];
                    w_state_nxt = FLUSH;
                    w_fcnt_nxt  = FCNT_W'(FLUSH_CYC);
                    w_flush_nxt = 1'b1;
                    w_redir     = 1'b1;
                end else begin
                    if (!Stall) begin
                        w_pc_nxt = r_pc + PC_W'(PC_STEP);
                    end
                    w_fcnt_nxt  = w_fcnt_dec;
                    w_flush_nxt = (w_fcnt_dec != '0);
                    w_state_nxt = (w_fcnt_dec != '0) ? FLUSH : RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= RUN;
            r_pc     <= '0;
            r_fcnt   <= '0;
            r_flush  <= 1'b0;
            r_halted <= 1'b0;
            r_trap   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_fcnt   <= w_fcnt_nxt;
            r_flush  <= w_flush_nxt;
            r_halted <= (w_state_nxt == HALT);
            r_trap   <= w_trap_nxt;
        end
    end

    sat_counter #(.W(CNT_W)) u_redir_cnt (
        .clk    (clk),
        .resetn (reset),
        .i_en   (w_redir),
        .o_cnt  (RedirectCnt)
    );

    assign PC     = r_pc;
    assign Flush  = r_flush;
    assign Halted = r_halted;
    assign Trap   = r_trap;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - directed and random checks of pc_fetch_ctrl against a behavioural model
module tb_pc_fetch_ctrl;

    localparam int PC_W = 9;
    localparam int FC   = 2;

    logic        clk = 1'b0;
    logic        reset, Stall, PcSel, Halt;
    logic [31:0] BrPC;
    logic [PC_W-1:0] PC, PC2;
    logic        Flush, Halted, Trap, Flush2, Halted2, Trap2;
    logic [15:0] RedirectCnt;
    logic [1:0]  RedirectCnt2;

    int n_vec = 0;
    int n_err = 0;

    int m_pc, m_left, m_cnt, m_cnt2;
    bit m_halted, m_trap, m_flush;

    always #5 clk = ~clk;

    pc_fetch_ctrl #(.PC_W(PC_W), .FLUSH_CYC(FC), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .Stall(Stall), .PcSel(PcSel), .BrPC(BrPC), .Halt(Halt),
        .PC(PC), .Flush(Flush), .Halted(Halted), .Trap(Trap), .RedirectCnt(RedirectCnt)
    );

    pc_fetch_ctrl #(.PC_W(PC_W), .FLUSH_CYC(FC), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .Stall(Stall), .PcSel(PcSel), .BrPC(BrPC), .Halt(Halt),
        .PC(PC2), .Flush(Flush2), .Halted(Halted2), .Trap(Trap2), .RedirectCnt(RedirectCnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit mis;
        mis = PcSel && (BrPC[1:0] != 2'b00);
        if (!reset) begin
            m_pc = 0; m_left = 0; m_cnt = 0; m_cnt2 = 0;
            m_halted = 0; m_trap = 0; m_flush = 0;
        end else if (m_halted) begin
            m_flush = 0;
        end else if (Halt || mis) begin
            m_halted = 1;
            m_flush  = 1;
            m_left   = 0;
            if (!Halt) m_trap = 1;
        end else if (PcSel) begin
            m_pc   = int'(BrPC) & ((1 << PC_W) - 1);
            m_cnt  = (m_cnt  < 65535) ? m_cnt + 1  : m_cnt;
            m_cnt2 = (m_cnt2 < 3)     ? m_cnt2 + 1 : m_cnt2;
            m_left = FC;
            m_flush = 1;
        end else begin
            if (!Stall) m_pc = (m_pc + 4) % (1 << PC_W);
            if (m_left > 0) m_left--;
            m_flush = (m_left > 0);
        end
    endtask

    task automatic tick(input bit rn, input bit s, input bit ps, input logic [31:0] bp, input bit h);
        reset = rn; Stall = s; PcSel = ps; BrPC = bp; Halt = h;
        @(posedge clk);
        model_step();
        #1;
        chk("pc",      32'(PC),           32'(m_pc));
        chk("flush",   32'(Flush),        32'(m_flush));
        chk("halted",  32'(Halted),       32'(m_halted));
        chk("trap",    32'(Trap),         32'(m_trap));
        chk("cnt",     32'(RedirectCnt),  32'(m_cnt));
        chk("cnt2",    32'(RedirectCnt2), 32'(m_cnt2));
        chk("pc2",     32'(PC2),          32'(m_pc));
    endtask

    task automatic idle();
        tick(1, 0, 0, 32'h0, 0);
    endtask

    initial begin
        int fl;
        logic [PC_W-1:0] pc_hold;
        logic [15:0]     cnt_hold;

        // Reset then five sequential fetches
        tick(0, 0, 0, 32'h0, 0);
        chk("rst_pc", 32'(PC), 32'h0);
        for (int i = 1; i <= 5; i++) begin
            idle();
            chk("seq_pc", 32'(PC), 32'(4 * i));
        end
        chk("seq_flush", 32'(Flush), 32'h0);

        // Redirect at PC=8
        tick(0, 0, 0, 32'h0, 0);
        idle(); idle();
        chk("pre_redir_pc", 32'(PC), 32'h8);
        tick(1, 0, 1, 32'h40, 0);
        chk("redir_pc", 32'(PC), 32'h40);
        chk("redir_fl0", 32'(Flush), 32'h1);
        idle();
        chk("redir_pc1", 32'(PC), 32'h44);
        chk("redir_fl1", 32'(Flush), 32'h1);
        idle();
        chk("redir_pc2", 32'(PC), 32'h48);
        chk("redir_fl2", 32'(Flush), 32'h0);
        chk("redir_cnt", 32'(RedirectCnt), 32'h1);

        // Redirect beats stall; back-to-back redirect restarts the countdown
        fl = 0;
        tick(1, 1, 1, 32'h100, 0);
        chk("stall_redir_pc", 32'(PC), 32'h100);
        fl += int'(Flush);
        tick(1, 0, 1, 32'h20, 0);
        fl += int'(Flush);
        idle(); fl += int'(Flush);
        idle(); fl += int'(Flush);
        chk("restart_flush_cycles", 32'(fl), 32'd3);

        // Stall hold at 0x10
        tick(1, 0, 1, 32'h10, 0);
        for (int i = 0; i < 3; i++) begin
            tick(1, 1, 0, 32'h0, 0);
            chk("stall_pc", 32'(PC), 32'h10);
        end
        idle();
        chk("stall_release_pc", 32'(PC), 32'h14);

        // Misaligned target traps and halts
        pc_hold  = PC;
        cnt_hold = RedirectCnt;
        tick(1, 0, 1, 32'h42, 0);
        chk("trap_set", 32'(Trap), 32'h1);
        chk("trap_halted", 32'(Halted), 32'h1);
        chk("trap_pc", 32'(PC), 32'(pc_hold));
        chk("trap_cnt", 32'(RedirectCnt), 32'(cnt_hold));
        for (int i = 0; i < 3; i++) begin
            tick(1, 0, 1, 32'h80, 0);
            chk("halt_pc_frozen", 32'(PC), 32'(pc_hold));
            chk("halt_flush_low", 32'(Flush), 32'h0);
        end
        tick(0, 0, 0, 32'h0, 0);
        chk("unhalt_pc", 32'(PC), 32'h0);
        chk("unhalt_trap", 32'(Trap), 32'h0);
        chk("unhalt_halted", 32'(Halted), 32'h0);

        // PC wrap and counter saturation
        tick(1, 0, 1, 32'hFFFF_FFFC, 0);
        chk("wrap_pre", 32'(PC), 32'h1FC);
        idle();
        chk("wrap_pc", 32'(PC), 32'h0);
        tick(0, 0, 0, 32'h0, 0);
        for (int i = 0; i < 5; i++) tick(1, 0, 1, 32'h80, 0);
        chk("sat_cnt2", 32'(RedirectCnt2), 32'h3);
        chk("sat_cnt16", 32'(RedirectCnt), 32'h5);

        // Halt instruction
        tick(1, 0, 0, 32'h0, 1);
        chk("halt_flag", 32'(Halted), 32'h1);
        chk("halt_flush_pulse", 32'(Flush), 32'h1);
        idle();
        chk("halt_flush_drop", 32'(Flush), 32'h0);
        tick(0, 0, 0, 32'h0, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            bit rn, s, ps, h;
            logic [31:0] bp;
            rn = ($urandom_range(0, 29) != 0);
            if (m_halted && $urandom_range(0, 5) == 0) rn = 0;
            s  = ($urandom_range(0, 3) == 0);
            ps = ($urandom_range(0, 4) == 0);
            h  = ($urandom_range(0, 49) == 0);
            bp = $urandom;
            if ($urandom_range(0, 7) != 0) bp[1:0] = 2'b00;
            tick(rn, s, ps, bp, h);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
